// File: rtl/key_event_ctrl.sv
// Debounced multi-key front end: press/long/repeat/release events queued into a FWFT FIFO.
// Define KEY_AUTOREPEAT_EN to emit REPEAT events while a key stays in the long-held state.
module key_event_lane #(
  parameter int DEBOUNCE_CYC = 250,
  parameter int LONG_CYC     = 25000,
  parameter int REPEAT_CYC   = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  input  logic       grant,
  output logic       level,
  output logic       pend_vld,
  output logic [1:0] pend_type,
  output logic       ovf_set
);
  localparam int DW   = $clog2(DEBOUNCE_CYC);
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX);
  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_LONG    = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b11;
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] EV_REPEAT  = 2'b10;
`endif

  typedef enum logic [1:0] {ST_RELEASED, ST_HELD, ST_LONG_HELD} state_e;

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_vld_q, pend_vld_d;
  logic [1:0]    pend_type_q, pend_type_d;
  logic          evt;
  logic [1:0]    evt_type;

  always_comb begin
    sync_d   = {sync_q[0], key_raw};
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) level_d = ~level_q;
      else                                   db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // FSM works off the registered level, so events trail KEY_LEVEL by one cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    evt      = 1'b0;
    evt_type = EV_PRESS;
    case (state_q)
      ST_RELEASED: if (level_q) begin
        state_d = ST_HELD; hold_d = '0; evt = 1'b1; evt_type = EV_PRESS;
      end
      ST_HELD: begin
        if (!level_q) begin
          state_d = ST_RELEASED; hold_d = '0; evt = 1'b1; evt_type = EV_RELEASE;
        end else if (hold_q == HW'(LONG_CYC - 1)) begin
          state_d = ST_LONG_HELD; hold_d = '0; evt = 1'b1; evt_type = EV_LONG;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!level_q) begin
          state_d = ST_RELEASED; hold_d = '0; evt = 1'b1; evt_type = EV_RELEASE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (hold_q == HW'(REPEAT_CYC - 1)) begin
          hold_d = '0; evt = 1'b1; evt_type = EV_REPEAT;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  // A grant in the same cycle frees the slot, so the new event is not an overwrite.
  always_comb begin
    pend_vld_d  = pend_vld_q & ~grant;
    pend_type_d = pend_type_q;
    ovf_set     = 1'b0;
    if (evt) begin
      pend_vld_d  = 1'b1;
      pend_type_d = evt_type;
      ovf_set     = pend_vld_q & ~grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      state_q     <= ST_RELEASED;
      hold_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_type_q <= '0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      pend_vld_q  <= pend_vld_d;
      pend_type_q <= pend_type_d;
    end
  end

  assign level     = level_q;
  assign pend_vld  = pend_vld_q;
  assign pend_type = pend_type_q;
endmodule

module key_event_ctrl #(
  parameter int N_KEYS       = 5,
  parameter int DEBOUNCE_CYC = 250,
  parameter int LONG_CYC     = 25000,
  parameter int REPEAT_CYC   = 5000,
  parameter int FIFO_DEPTH   = 4,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [KW-1:0]     EVT_KEY,
  output logic [1:0]        EVT_TYPE,
  output logic [CW-1:0]     FIFO_COUNT,
  output logic              OVERFLOW,
  input  logic              CLR_OVERFLOW
);
  logic [N_KEYS-1:0]      pend_vld, grant, ovf_set;
  logic [N_KEYS-1:0][1:0] pend_type;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_lane
    key_event_lane #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_lane (
      .clk      (CLK),
      .rst      (RESET),
      .key_raw  (KEY[k]),
      .grant    (grant[k]),
      .level    (KEY_LEVEL[k]),
      .pend_vld (pend_vld[k]),
      .pend_type(pend_type[k]),
      .ovf_set  (ovf_set[k])
    );
  end

  logic [FIFO_DEPTH-1:0][KW+1:0] mem_q, mem_d;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic                          pop, push, can_push;
  logic [KW-1:0]                 push_key;
  logic [1:0]                    push_type;

  // Fixed priority: lowest key index wins; a full FIFO may still take one if it pops.
  always_comb begin
    pop       = (cnt_q != '0) & EVT_READY;
    can_push  = (cnt_q != CW'(FIFO_DEPTH)) | pop;
    grant     = '0;
    push      = 1'b0;
    push_key  = '0;
    push_type = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (pend_vld[k] && !push && can_push) begin
        grant[k]  = 1'b1;
        push      = 1'b1;
        push_key  = KW'(k);
        push_type = pend_type[k];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {push_key, push_type};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (|ovf_set)          ovf_d = 1'b1;
    else if (CLR_OVERFLOW) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign EVT_VALID  = (cnt_q != '0);
  assign EVT_KEY    = mem_q[rd_ptr_q][KW+1:2];
  assign EVT_TYPE   = mem_q[rd_ptr_q][1:0];
  assign FIFO_COUNT = cnt_q;
  assign OVERFLOW   = ovf_q;
endmodule
